// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: memory geometry, writeback source select, M/W register.
package pipeline_pkg;

  localparam int DEFAULT_DEPTH  = 1024;
  localparam int DEFAULT_ADDR_W = 10;

  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] read_data;
  } mw_reg_t;

  // Only loads and stores can be misaligned; ALU-only instructions never flag.
  function automatic logic is_misaligned(input logic [1:0] byte_off, input logic mem_access);
    return mem_access && (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous full-word write.
// A read of the index being written returns the old word; contents survive reset.
module data_memory
  import pipeline_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[addr] <= wd;
    end
  end

  assign rd = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data-memory access plus the M/W pipeline register and writeback result mux.
// Optional MEM_MISALIGN_CHECK_EN adds MisalignW and suppresses misaligned stores/loads.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        MisalignW
`endif
);

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       mem_rd;
  logic [31:0]       load_data;
  logic              mem_we;
  mw_reg_t           mw_d;
  mw_reg_t           mw_q;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH*4 bytes.
  assign word_idx = ALU_ResultM[ADDR_W+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = is_misaligned(ALU_ResultM[1:0], MemWriteM || ResultSrcM);
  assign mem_we     = MemWriteM && !rst && !misaligned;
  assign load_data  = misaligned ? 32'h0 : mem_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misaligned;
    end
  end

  assign MisalignW = misalign_q;
`else
  assign mem_we    = MemWriteM && !rst;
  assign load_data = mem_rd;
`endif

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_memory (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .addr (word_idx),
    .wd   (WriteDataM),
    .rd   (mem_rd)
  );

  always_comb begin
    mw_d            = '0;
    mw_d.reg_write  = RegWriteM;
    mw_d.result_src = ResultSrcM;
    mw_d.rd         = RD_M;
    mw_d.pc_plus4   = PCPlus4M;
    mw_d.alu_result = ALU_ResultM;
    mw_d.read_data  = load_data;
  end

  // No stall input: the register advances every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mw_q <= '0;
    end else begin
      mw_q <= mw_d;
    end
  end

  assign RegWriteW   = mw_q.reg_write;
  assign ResultSrcW  = mw_q.result_src;
  assign RD_W        = mw_q.rd;
  assign PCPlus4W    = mw_q.pc_plus4;
  assign ALU_ResultW = mw_q.alu_result;
  assign ReadDataW   = mw_q.read_data;

  assign ResultW = (mw_q.result_src == RESULT_SRC_MEM) ? mw_q.read_data : mw_q.alu_result;

endmodule

// File: tb/tb_memory_stage.sv
// Directed table-driven bench for memory_stage, with hand sequences for misalignment corners.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        MisalignW;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .ResultW     (ResultW)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .MisalignW   (MisalignW)
`endif
  );

  typedef struct {
    logic        rst, mw, rs, rw;
    logic [4:0]  rd;
    logic [31:0] pc, wd, alu;
    logic        ex_rw, ex_rs;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_alu, ex_rdata, ex_res;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic mw, input logic rs, input logic rw,
                      input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                      input logic [31:0] alu);
    @(negedge clk);
    rst = r; MemWriteM = mw; ResultSrcM = rs; RegWriteM = rw;
    RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic mw, input logic rs, input logic rw,
                              input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                              input logic [31:0] alu, input logic erw, input logic ers,
                              input logic [4:0] erd, input logic [31:0] epc, input logic [31:0] ealu,
                              input logic [31:0] erdata, input logic [31:0] eres);
    vec_t v;
    v.rst = r; v.mw = mw; v.rs = rs; v.rw = rw; v.rd = rd; v.pc = pc; v.wd = wd; v.alu = alu;
    v.ex_rw = erw; v.ex_rs = ers; v.ex_rd = erd; v.ex_pc = epc; v.ex_alu = ealu;
    v.ex_rdata = erdata; v.ex_res = eres;
    return v;
  endfunction

  initial begin
    // Reset held two cycles with a store pending; the store must not land.
    vt[0]  = mk(1,1,1,1, 7, 32'h4,   32'hDEAD,     32'h10,       0,0, 0, 0,       0,            0,            0);
    vt[1]  = mk(1,1,1,1, 7, 32'h4,   32'hDEAD,     32'h10,       0,0, 0, 0,       0,            0,            0);
    vt[2]  = mk(0,0,1,1, 3, 32'h100, 0,            32'h10,       1,1, 3, 32'h100, 32'h10,       32'hA0000010, 32'hA0000010);
    vt[3]  = mk(0,1,0,0, 0, 32'h104, 32'h12345678, 32'h20,       0,0, 0, 32'h104, 32'h20,       32'hA0000020, 32'h20);
    vt[4]  = mk(0,0,1,1, 9, 32'h108, 0,            32'h20,       1,1, 9, 32'h108, 32'h20,       32'h12345678, 32'h12345678);
    vt[5]  = mk(0,0,0,1, 5, 32'h10C, 0,            32'h30,       1,0, 5, 32'h10C, 32'h30,       32'hA0000030, 32'h30);
    vt[6]  = mk(0,1,0,0, 0, 32'h110, 32'h11,       32'h40,       0,0, 0, 32'h110, 32'h40,       32'hA0000040, 32'h40);
    vt[7]  = mk(0,1,1,1, 4, 32'h114, 32'h22,       32'h40,       1,1, 4, 32'h114, 32'h40,       32'h11,       32'h11);
    vt[8]  = mk(0,0,1,1, 4, 32'h118, 0,            32'h40,       1,1, 4, 32'h118, 32'h40,       32'h22,       32'h22);
    vt[9]  = mk(0,1,0,0, 0, 32'h11C, 32'hAA,       32'h1000,     0,0, 0, 32'h11C, 32'h1000,     32'hA0000000, 32'h1000);
    vt[10] = mk(0,0,1,1,31, 32'h120, 0,            32'h0,        1,1,31, 32'h120, 32'h0,        32'hAA,       32'hAA);
    vt[11] = mk(0,1,0,0, 0, 32'h124, 32'hBEEF,     32'hFFFFFFFC, 0,0, 0, 32'h124, 32'hFFFFFFFC, 32'hA0000FFC, 32'hFFFFFFFC);
    vt[12] = mk(0,0,1,1, 2, 32'h128, 0,            32'h3FFC,     1,1, 2, 32'h128, 32'h3FFC,     32'hBEEF,     32'hBEEF);

    rst = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; RegWriteM = 1'b0;
    RD_M = '0; PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0;

    // Seed every word the table touches so all expected read data is known.
    step(0,1,0,0,0,0,32'hA0000000,32'h0);
    step(0,1,0,0,0,0,32'hA0000010,32'h10);
    step(0,1,0,0,0,0,32'hA0000020,32'h20);
    step(0,1,0,0,0,0,32'hA0000030,32'h30);
    step(0,1,0,0,0,0,32'hA0000040,32'h40);
    step(0,1,0,0,0,0,32'hA0000FFC,32'hFFC);

    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst, vt[i].mw, vt[i].rs, vt[i].rw, vt[i].rd, vt[i].pc, vt[i].wd, vt[i].alu);
      check($sformatf("v%0d.RegWriteW", i),   {31'b0, RegWriteW},  {31'b0, vt[i].ex_rw});
      check($sformatf("v%0d.ResultSrcW", i),  {31'b0, ResultSrcW}, {31'b0, vt[i].ex_rs});
      check($sformatf("v%0d.RD_W", i),        {27'b0, RD_W},       {27'b0, vt[i].ex_rd});
      check($sformatf("v%0d.PCPlus4W", i),    PCPlus4W,            vt[i].ex_pc);
      check($sformatf("v%0d.ALU_ResultW", i), ALU_ResultW,         vt[i].ex_alu);
      check($sformatf("v%0d.ReadDataW", i),   ReadDataW,           vt[i].ex_rdata);
      check($sformatf("v%0d.ResultW", i),     ResultW,             vt[i].ex_res);
`ifdef MEM_MISALIGN_CHECK_EN
      check($sformatf("v%0d.MisalignW", i),   {31'b0, MisalignW},  32'h0);
`endif
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned store is dropped and flags for exactly one cycle.
    step(0,1,0,0,0,32'h200,32'h99,32'h42);
    check("mis_store.MisalignW", {31'b0, MisalignW}, 32'h1);
    step(0,0,0,1,1,32'h204,0,32'h7);
    check("mis_store.MisalignW_clear", {31'b0, MisalignW}, 32'h0);
    check("alu_low_bits.ResultW", ResultW, 32'h7);
    step(0,0,1,1,1,32'h208,0,32'h40);
    check("mis_store.mem_unchanged", ReadDataW, 32'h22);
    check("mis_store.MisalignW_load", {31'b0, MisalignW}, 32'h0);
    step(0,0,1,1,1,32'h20C,0,32'h41);
    check("mis_load.ReadDataW", ReadDataW, 32'h0);
    check("mis_load.MisalignW", {31'b0, MisalignW}, 32'h1);
`else
    // Byte offset is ignored: access lands on the containing word.
    step(0,0,1,1,1,32'h200,0,32'h42);
    check("offset_load.ReadDataW", ReadDataW, 32'h22);
    step(0,1,0,0,0,32'h204,32'h77,32'h43);
    step(0,0,1,1,1,32'h208,0,32'h40);
    check("offset_store.ReadDataW", ReadDataW, 32'h77);
    check("offset_store.ResultW", ResultW, 32'h77);
`endif

    // Mid-run reset clears W outputs; memory keeps its contents.
    step(1,0,1,1,6,32'h300,0,32'h20);
    check("rst2.ResultW", ResultW, 32'h0);
    check("rst2.RD_W", {27'b0, RD_W}, 32'h0);
    step(0,0,1,1,6,32'h304,0,32'h20);
    check("rst2.mem_kept", ReadDataW, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage pipelined processor: consumes the E/M pipeline register outputs produced by the execute stage, performs the data-memory load/store, and registers the result into the M/W pipeline register for writeback. It also produces `ResultW`, the writeback value fed back to the execute stage's forwarding muxes (`ForwardA_E`/`ForwardB_E` = 2'b01). It contains the data memory as a sub-module.

## Interface
Parameters:
- `DEPTH`, 1024: data-memory size in 32-bit words (power of two).
- `ADDR_W`, 10: word-index width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RegWriteM`  in  1  register-file write enable for the instruction in M.
- `MemWriteM`  in  1  data-memory store enable.
- `ResultSrcM`  in  1  0 = writeback ALU result, 1 = writeback load data.
- `RD_M`  in  5  destination register.
- `PCPlus4M`  in  32  PC+4 pass-through.
- `WriteDataM`  in  32  store data (already forwarded in E).
- `ALU_ResultM`  in  32  byte address for loads/stores, or the ALU result.
- `RegWriteW`  out  1  registered `RegWriteM`.
- `ResultSrcW`  out  1  registered `ResultSrcM`.
- `RD_W`  out  5  registered `RD_M`.
- `PCPlus4W`  out  32  registered `PCPlus4M`.
- `ALU_ResultW`  out  32  registered `ALU_ResultM`.
- `ReadDataW`  out  32  registered load data.
- `ResultW`  out  32  combinational: `ResultSrcW ? ReadDataW : ALU_ResultW`.
- `MisalignW`  out  1  present only with `MEM_MISALIGN_CHECK_EN`; registered misalignment flag.

## Operation
- Word index = `ALU_ResultM[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`. Bits [1:0] are ignored unless the macro is defined.
- Read is asynchronous: `ReadDataM = mem[index]`. It is captured into `ReadDataW` at the clock edge.
- Write is synchronous: on the rising edge with `MemWriteM` = 1, `mem[index] <= WriteDataM`, full word.
- Read and write to the same index in the same cycle: `ReadDataW` receives the OLD contents. The new value is visible from the next cycle.
- The M/W register updates every cycle, with no stall or enable.
- Reset (`rst` = 1 at an edge):
  - `RegWriteW`, `ResultSrcW`, `MisalignW` = 0.
  - `RD_W` = 0.
  - `PCPlus4W`, `ALU_ResultW`, `ReadDataW` = 0.
  - Therefore `ResultW` = 0.
  - Memory contents are NOT cleared.
  - A store presented in the same cycle as `rst` is suppressed (write enable = `MemWriteM & ~rst`).
- A load with `ResultSrcM` = 1 and `RegWriteM` = 0 still captures `ReadDataW`. It is harmless.

## Timing
- M to W latency: 1 cycle for all registered outputs.
- `ResultW` is valid combinationally from the W registers in the same cycle. The execute stage samples it through forwarding.
- Store to load at the same address in the next instruction: the load returns the stored value, with no hazard inside this block.
- The first edge after `rst` deasserts loads real data.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - misaligned = `ALU_ResultM[1:0] != 0` while (`MemWriteM` or `ResultSrcM`).
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load returns 0 in `ReadDataW`.
  - `MisalignW` = registered misaligned flag, asserted for exactly one cycle per offending instruction.
- Undefined: no `MisalignW` port. Address bits [1:0] are ignored; access goes to the containing word.

## Structure
- Shared package `pipeline_pkg` holds:
  - the default `DEPTH`/`ADDR_W` constants;
  - `RESULT_SRC_ALU` = 1'b0 and `RESULT_SRC_MEM` = 1'b1;
  - the M/W pipeline-register struct type.
- One sub-module, `data_memory`, with ports: `clk`, `rst`, `we`, `addr[ADDR_W-1:0]`, `wd[31:0]`, `rd[31:0]` (async read, sync write). Pipeline register and result mux stay in `memory_stage`.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `MemWriteM` = 1, `ALU_ResultM` = 0x10, `WriteDataM` = 0xDEAD → all W outputs 0; a subsequent load of 0x10 does not return 0xDEAD.
- Store then load: store 0x12345678 at 0x20, next cycle load 0x20 with `ResultSrcM` = 1 → after 1 cycle `ReadDataW` = `ResultW` = 0x12345678.
- ALU passthrough: `ALU_ResultM` = 0x30, `ResultSrcM` = 0, `RD_M` = 5, `RegWriteM` = 1 → next cycle `ResultW` = 0x30, `RD_W` = 5, `RegWriteW` = 1.
- Read-during-write: mem[0x40] = 0x11; same cycle, store 0x22 and read 0x40 → `ReadDataW` = 0x11; the following load gives 0x22.
- Wrap-around with `DEPTH` = 1024: store 0xAA at 0x1000 → load at 0x0 returns 0xAA.
- With `MEM_MISALIGN_CHECK_EN`: store to 0x42 → memory unchanged and `MisalignW` = 1 for 1 cycle; load from 0x41 → `ReadDataW` = 0.
